// File: rtl/platform_switch_pkg.sv
// rtl/platform_switch_pkg.sv - shared types and constants for switch conditioning
// Purpose: debounce FSM state encodings and the default qualification constant.
// Ports: none (package).
package platform_switch_pkg;

  typedef enum logic [1:0] {
    ST_LO = 2'b00,  // settled low
    ST_HI = 2'b01,  // settled high
    WT_HI = 2'b10,  // low, qualifying a candidate high
    WT_LO = 2'b11   // high, qualifying a candidate low
  } sw_state_e;

  // 1 ms of qualification at a 50 MHz system clock.
  localparam int SW_DEBOUNCE_CYCLES_50MHZ = 50000;

endpackage

// File: rtl/platform_debounce_bit.sv
// rtl/platform_debounce_bit.sv - synchroniser, debounce FSM and edge pulses for one line
// Purpose: clean one raw asynchronous switch line into a registered level and
//          single-cycle rise/fall pulses aligned with the level update.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high
//   sw_raw   - raw switch pin, asynchronous to clk
//   sw_level - debounced level (registered)
//   sw_rise  - 1-cycle pulse with the 0->1 level update
//   sw_fall  - 1-cycle pulse with the 1->0 level update
module platform_debounce_bit
  import platform_switch_pkg::*;
#(
  parameter int STABLE_CYCLES = SW_DEBOUNCE_CYCLES_50MHZ,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic sw_raw,
  output logic sw_level,
  output logic sw_rise,
  output logic sw_fall
);

  localparam int               CNT_W     = $clog2(STABLE_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(STABLE_CYCLES - 1);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam sw_state_e        RST_STATE = RESET_LEVEL ? ST_HI : ST_LO;

  logic             s1, s2;
  sw_state_e        state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             level_d, rise_d, fall_d;

  always_ff @(posedge clk) begin
    if (reset) begin
      // Synchroniser preloads the reset level so the first evaluation after
      // release cannot see a spurious transition.
      s1       <= RESET_LEVEL;
      s2       <= RESET_LEVEL;
      state_q  <= RST_STATE;
      cnt_q    <= '0;
      sw_level <= RESET_LEVEL;
      sw_rise  <= 1'b0;
      sw_fall  <= 1'b0;
    end else begin
      s1       <= sw_raw;
      s2       <= s1;
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      sw_level <= level_d;
      sw_rise  <= rise_d;
      sw_fall  <= fall_d;
    end
  end

  // The sample that moves a settled state into WT_* is the first qualifying
  // sample, hence cnt starts at 1 and acceptance happens on cnt = last.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    level_d = sw_level;
    rise_d  = 1'b0;
    fall_d  = 1'b0;
    case (state_q)
      ST_LO: begin
        if (s2) begin
          state_d = WT_HI;
          cnt_d   = CNT_ONE;
        end
      end
      WT_HI: begin
        if (!s2) begin
          state_d = ST_LO;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_HI;
          cnt_d   = '0;
          level_d = 1'b1;
          rise_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      ST_HI: begin
        if (!s2) begin
          state_d = WT_LO;
          cnt_d   = CNT_ONE;
        end
      end
      WT_LO: begin
        if (s2) begin
          state_d = ST_HI;
          cnt_d   = '0;
        end else if (cnt_q == CNT_LAST) begin
          state_d = ST_LO;
          cnt_d   = '0;
          level_d = 1'b0;
          fall_d  = 1'b1;
        end else begin
          cnt_d = cnt_q + CNT_ONE;
        end
      end
      default: begin
        state_d = RST_STATE;
        cnt_d   = '0;
      end
    endcase
  end

endmodule

// File: rtl/platform_switch_debounce.sv
// rtl/platform_switch_debounce.sv - WIDTH independent debounced switch lines for the PIO
// Purpose: one platform_debounce_bit per switch line; no shared logic.
// Ports:
//   clk      - system clock, rising edge
//   reset    - synchronous, active-high
//   sw_raw   - raw switch pins [WIDTH]
//   sw_level - debounced levels to PIO in_port [WIDTH]
//   sw_rise  - per-bit 1-cycle rise pulses [WIDTH]
//   sw_fall  - per-bit 1-cycle fall pulses [WIDTH]
module platform_switch_debounce
  import platform_switch_pkg::*;
#(
  parameter int WIDTH         = 1,
  parameter int STABLE_CYCLES = SW_DEBOUNCE_CYCLES_50MHZ,
  parameter bit RESET_LEVEL   = 1'b0
) (
  input  logic             clk,
  input  logic             reset,
  input  logic [WIDTH-1:0] sw_raw,
  output logic [WIDTH-1:0] sw_level,
  output logic [WIDTH-1:0] sw_rise,
  output logic [WIDTH-1:0] sw_fall
);

  for (genvar i = 0; i < WIDTH; i++) begin : g_bit
    platform_debounce_bit #(
      .STABLE_CYCLES(STABLE_CYCLES),
      .RESET_LEVEL  (RESET_LEVEL)
    ) u_bit (
      .clk     (clk),
      .reset   (reset),
      .sw_raw  (sw_raw[i]),
      .sw_level(sw_level[i]),
      .sw_rise (sw_rise[i]),
      .sw_fall (sw_fall[i])
    );
  end

endmodule

// File: tb/tb_platform_switch_debounce.sv
// tb/tb_platform_switch_debounce.sv - scoreboard bench for platform_switch_debounce
module tb_platform_switch_debounce;

  typedef struct {
    int         cyc;
    logic [1:0] lvl;
    logic [1:0] rise;
    logic [1:0] fall;
  } ev_t;

  logic       clk = 1'b0;
  int         cyc = 0;
  int         compared = 0;
  int         mismatched = 0;

  // dut a: RESET_LEVEL=0, dut b: RESET_LEVEL=1
  logic       reset_a = 1'b1, reset_b = 1'b1;
  logic [1:0] raw_a = 2'b11, raw_b = 2'b11;
  logic [1:0] lvl_a, rise_a, fall_a;
  logic [1:0] lvl_b, rise_b, fall_b;
  logic [1:0] prev_a, prev_b;
  bit         mon_a = 1'b0, mon_b = 1'b0;
  ev_t        qa[$];
  ev_t        qb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  platform_switch_debounce #(.WIDTH(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b0)) u_dut_a (
    .clk(clk), .reset(reset_a), .sw_raw(raw_a),
    .sw_level(lvl_a), .sw_rise(rise_a), .sw_fall(fall_a)
  );

  platform_switch_debounce #(.WIDTH(2), .STABLE_CYCLES(4), .RESET_LEVEL(1'b1)) u_dut_b (
    .clk(clk), .reset(reset_b), .sw_raw(raw_b),
    .sw_level(lvl_b), .sw_rise(rise_b), .sw_fall(fall_b)
  );

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic push(input int d, input int c, input logic [1:0] l, input logic [1:0] r,
                      input logic [1:0] f);
    ev_t e;
    e.cyc = c; e.lvl = l; e.rise = r; e.fall = f;
    if (d == 0) qa.push_back(e);
    else        qb.push_back(e);
  endtask

  task automatic check_now(input string name, input logic [5:0] got, input logic [5:0] exp);
    compared++;
    if (got !== exp) begin
      mismatched++;
      $display("FAIL %s: got {lvl,rise,fall}=%b, required %b", name, got, exp);
    end
  endtask

  task automatic check_ev(input int d, input logic [1:0] l, input logic [1:0] r,
                          input logic [1:0] f);
    ev_t e;
    bit  have;
    have = 1'b0;
    if (d == 0) begin
      if (qa.size() > 0) begin e = qa.pop_front(); have = 1'b1; end
    end else begin
      if (qb.size() > 0) begin e = qb.pop_front(); have = 1'b1; end
    end
    compared++;
    if (!have) begin
      mismatched++;
      $display("FAIL unexpected_event dut%0d: cyc=%0d lvl=%b rise=%b fall=%b, required no event",
               d, cyc, l, r, f);
    end else if (e.cyc != cyc || e.lvl !== l || e.rise !== r || e.fall !== f) begin
      mismatched++;
      $display("FAIL event dut%0d: got cyc=%0d lvl=%b rise=%b fall=%b, required cyc=%0d lvl=%b rise=%b fall=%b",
               d, cyc, l, r, f, e.cyc, e.lvl, e.rise, e.fall);
    end
  endtask

  // Monitor: any level change or any pulse is an output event to be matched.
  always @(negedge clk) begin
    if (mon_a && ((lvl_a !== prev_a) || (rise_a !== 2'b00) || (fall_a !== 2'b00)))
      check_ev(0, lvl_a, rise_a, fall_a);
    if (mon_b && ((lvl_b !== prev_b) || (rise_b !== 2'b00) || (fall_b !== 2'b00)))
      check_ev(1, lvl_b, rise_b, fall_b);
    prev_a = lvl_a;
    prev_b = lvl_b;
  end

  initial begin
    // 1: reset held 3 cycles with raw=11, then release
    for (int i = 0; i < 3; i++) begin
      tick(1);
      check_now("reset_hold_a", {lvl_a, rise_a, fall_a}, 6'b00_00_00);
    end
    reset_a = 1'b0;
    mon_a   = 1'b1;
    push(0, cyc + 6, 2'b11, 2'b11, 2'b00);
    tick(10);

    // 2: bit0 down, then clean rise on bit0; bit1 stays high
    raw_a = 2'b10; push(0, cyc + 6, 2'b10, 2'b00, 2'b01); tick(8);
    raw_a = 2'b11; push(0, cyc + 6, 2'b11, 2'b01, 2'b00); tick(8);

    // 3: bounce 1,0,1,1,1,0 on bit0 from level 0 must be rejected
    raw_a = 2'b10; push(0, cyc + 6, 2'b10, 2'b00, 2'b01); tick(8);
    raw_a = 2'b11; tick(1);
    raw_a = 2'b10; tick(1);
    raw_a = 2'b11; tick(3);
    raw_a = 2'b10; tick(10);
    check_now("bounce_rejected", {lvl_a, rise_a, fall_a}, 6'b10_00_00);

    // 4: clean fall, 4-cycle low pulse accepted, 3-cycle low pulse rejected
    raw_a = 2'b11; push(0, cyc + 6, 2'b11, 2'b01, 2'b00); tick(8);
    raw_a = 2'b10; push(0, cyc + 6, 2'b10, 2'b00, 2'b01); tick(8);
    raw_a = 2'b11; push(0, cyc + 6, 2'b11, 2'b01, 2'b00); tick(8);
    raw_a = 2'b10; push(0, cyc + 6, 2'b10, 2'b00, 2'b01); tick(4);
    raw_a = 2'b11; push(0, cyc + 6, 2'b11, 2'b01, 2'b00); tick(10);
    raw_a = 2'b10; tick(3);
    raw_a = 2'b11; tick(10);
    check_now("short_low_rejected", {lvl_a, rise_a, fall_a}, 6'b11_00_00);

    // independence: bit1 falls, bit0 falls two cycles later
    raw_a = 2'b01; push(0, cyc + 6, 2'b01, 2'b00, 2'b10); tick(2);
    raw_a = 2'b00; push(0, cyc + 6, 2'b00, 2'b00, 2'b01); tick(10);

    // 5: reset while bit0 is in WT_HI with cnt=2
    raw_a = 2'b01; tick(4);
    reset_a = 1'b1; tick(1);
    check_now("mid_wait_reset", {lvl_a, rise_a, fall_a}, 6'b00_00_00);
    reset_a = 1'b0;
    push(0, cyc + 6, 2'b01, 2'b01, 2'b00);
    tick(5);
    check_now("post_reset_not_early", {lvl_a, rise_a, fall_a}, 6'b00_00_00);
    tick(5);

    // 6: RESET_LEVEL=1 with raw high through reset
    check_now("reset_level_one", {lvl_b, rise_b, fall_b}, 6'b11_00_00);
    reset_b = 1'b0;
    mon_b   = 1'b1;
    tick(10);
    check_now("no_rise_after_release", {lvl_b, rise_b, fall_b}, 6'b11_00_00);
    raw_b = 2'b10; push(1, cyc + 6, 2'b10, 2'b00, 2'b01); tick(10);

    // expected events never seen
    while (qa.size() > 0) begin
      ev_t e;
      e = qa.pop_front();
      compared++; mismatched++;
      $display("FAIL missing_event dut0: got none, required cyc=%0d lvl=%b", e.cyc, e.lvl);
    end
    while (qb.size() > 0) begin
      ev_t e;
      e = qb.pop_front();
      compared++; mismatched++;
      $display("FAIL missing_event dut1: got none, required cyc=%0d lvl=%b", e.cyc, e.lvl);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
